// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode PC sequencing with jump, branch and stall handling
module pc_sequencer #(
  parameter int PC_W = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            j_op,
  input  logic            jr_op,
  input  logic            jal_op,
  input  logic            bne_op,
  input  logic            blt_op,
  input  logic            bex_op,
  input  logic [26:0]     target,
  input  logic [16:0]     imm,
  input  logic [31:0]     rd_val,
  input  logic            ne,
  input  logic            lt,
  input  logic            rstatus_nz,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] dec_pc,
  output logic            insn_valid,
  output logic            link_we,
  output logic [PC_W-1:0] link_pc,
  output logic            redirect
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] fetch_pc, fetch_n, dec_n, tgt, br_tgt;
  logic cond, run, unused;
  assign unused = ^{rd_val[31:PC_W], target[26:PC_W]};
  assign run = state == RUN;
  assign br_tgt = dec_pc + PC_W'(1) + PC_W'({{15{imm[16]}}, imm});
  // the highest-priority raised flag alone chooses both the condition and the target
  assign tgt = jr_op ? rd_val[PC_W-1:0] : (jal_op | j_op | bex_op) ? target[PC_W-1:0] : br_tgt;
  assign cond = jr_op | jal_op | j_op | (bex_op ? rstatus_nz : blt_op ? lt : bne_op & ne);
  assign redirect = run & ~stall & cond;
  assign link_we = run & ~stall & jal_op & ~jr_op;
  assign link_pc = dec_pc + PC_W'(1);
  assign insn_valid = run;
  assign imem_addr = fetch_pc;
  always_comb begin
    state_n = stall ? state : redirect ? FLUSH : RUN;
    fetch_n = stall ? fetch_pc : redirect ? tgt : fetch_pc + PC_W'(1);
    dec_n = (stall | redirect) ? dec_pc : fetch_pc;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= BOOT;
      fetch_pc <= '0;
      dec_pc <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_n;
      dec_pc <= dec_n;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer against a PC-level model
module tb_pc_sequencer;
  localparam int M = 4096;
  logic clock, reset, stall, j_op, jr_op, jal_op, bne_op, blt_op, bex_op, ne, lt, rstatus_nz;
  logic [26:0] target;
  logic [16:0] imm;
  logic [31:0] rd_val;
  logic [11:0] imem_addr, dec_pc, link_pc;
  logic insn_valid, link_we, redirect;
  int n_chk = 0, n_fail = 0;
  int mf = 0, md = 0;
  bit mv = 0;

  pc_sequencer #(.PC_W(12)) dut (
    .clock(clock), .reset(reset), .stall(stall), .j_op(j_op), .jr_op(jr_op), .jal_op(jal_op),
    .bne_op(bne_op), .blt_op(blt_op), .bex_op(bex_op), .target(target), .imm(imm), .rd_val(rd_val),
    .ne(ne), .lt(lt), .rstatus_nz(rstatus_nz), .imem_addr(imem_addr), .dec_pc(dec_pc),
    .insn_valid(insn_valid), .link_we(link_we), .link_pc(link_pc), .redirect(redirect)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      $error("%s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {j_op, jr_op, jal_op, bne_op, blt_op, bex_op, ne, lt, rstatus_nz} = '0;
    target = '0; imm = '0; rd_val = '0;
  endtask

  // decide what the decode-stage instruction asks for, straight from the priority list
  task automatic ref_comb(output bit tk, output int tg, output bit jl);
    int si;
    si = imm[16] ? int'(imm) - 131072 : int'(imm);
    jl = 0;
    if (jr_op) begin tk = 1; tg = rd_val % M; end
    else if (jal_op) begin tk = 1; tg = target % M; jl = 1; end
    else if (j_op) begin tk = 1; tg = target % M; end
    else if (bex_op) begin tk = rstatus_nz; tg = target % M; end
    else if (blt_op) begin tk = lt; tg = ((md + 1 + si) % M + M) % M; end
    else if (bne_op) begin tk = ne; tg = ((md + 1 + si) % M + M) % M; end
    else begin tk = 0; tg = 0; end
  endtask

  task automatic step();
    bit tk, jl;
    int tg;
    #1;
    if (reset) begin mf = 0; md = 0; mv = 0; end
    ref_comb(tk, tg, jl);
    chk("imem_addr", imem_addr, mf);
    chk("dec_pc", dec_pc, md);
    chk("insn_valid", insn_valid, mv);
    chk("redirect", redirect, mv && !stall && tk);
    chk("link_we", link_we, mv && !stall && jl);
    chk("link_pc", link_pc, (md + 1) % M);
    @(posedge clock);
    if (reset) begin mf = 0; md = 0; mv = 0; end
    else if (!stall) begin
      if (mv && tk) begin mf = tg; mv = 0; end
      else begin md = mf; mf = (mf + 1) % M; mv = 1; end
    end
    #1;
  endtask

  task automatic jump_to(int a);
    j_op = 1; target = 27'(a);
    step();
    clr();
    step();
  endtask

  initial begin
    int k, f0;
    reset = 1; stall = 0; clr();
    #1;
    chk("rst_imem", imem_addr, 0);
    chk("rst_dec", dec_pc, 0);
    chk("rst_valid", insn_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_link_we", link_we, 0);
    step(); step();
    reset = 0;
    step();
    #1 chk("boot_imem1", imem_addr, 1); chk("boot_valid", insn_valid, 1); chk("boot_dec0", dec_pc, 0);
    step();
    #1 chk("boot_imem2", imem_addr, 2);
    step();
    #1 chk("boot_imem3", imem_addr, 3);
    k = 0;
    while (dec_pc != 5 && k < 20) begin step(); k++; end
    chk("reach_dec5", dec_pc, 5);
    jal_op = 1; target = 27'h100;
    #1 chk("jal_redirect", redirect, 1); chk("jal_link_we", link_we, 1); chk("jal_link_pc", link_pc, 6);
    step(); clr();
    #1 chk("jal_bubble", insn_valid, 0);
    step();
    #1 chk("jal_dec", dec_pc, 'h100); chk("jal_valid", insn_valid, 1);
    jump_to(10);
    bne_op = 1; ne = 1; imm = 17'h1FFFD;
    #1 chk("bne_redirect", redirect, 1); chk("bne_no_link", link_we, 0);
    step(); clr();
    #1 chk("bne_imem", imem_addr, 8);
    step();
    jump_to(10);
    bne_op = 1; ne = 0; imm = 17'h1FFFD;
    #1 chk("bne_nt_redirect", redirect, 0);
    step(); clr();
    #1 chk("bne_nt_imem", imem_addr, 12); chk("bne_nt_dec", dec_pc, 11);
    jr_op = 1; j_op = 1; rd_val = 32'h2A; target = 27'h50;
    step(); clr();
    #1 chk("jr_wins", imem_addr, 'h2A);
    step();
    f0 = mf;
    bex_op = 1; rstatus_nz = 1; target = 27'h77; stall = 1;
    repeat (3) begin
      #1 chk("stall_redirect", redirect, 0); chk("stall_imem", imem_addr, f0);
      step();
    end
    stall = 0;
    #1 chk("unstall_redirect", redirect, 1);
    step(); clr();
    #1 chk("bex_imem", imem_addr, 'h77);
    step();
    j_op = 1; target = 27'd4095;
    step(); clr();
    #1 chk("wrap_imem_top", imem_addr, 4095);
    step();
    #1 chk("wrap_imem0", imem_addr, 0); chk("wrap_dec", dec_pc, 4095); chk("wrap_link_pc", link_pc, 0);
    step();
    j_op = 1; target = 27'h30;
    step(); clr();
    reset = 1;
    #1 chk("flush_rst_imem", imem_addr, 0); chk("flush_rst_valid", insn_valid, 0); chk("flush_rst_dec", dec_pc, 0);
    step(); step();
    reset = 0;
    step();
    #1 chk("reboot_dec", dec_pc, 0); chk("reboot_valid", insn_valid, 1); chk("reboot_imem", imem_addr, 1);
    repeat (400) begin
      j_op = ($urandom_range(0, 3) == 0); jr_op = ($urandom_range(0, 7) == 0);
      jal_op = ($urandom_range(0, 5) == 0); bne_op = ($urandom_range(0, 3) == 0);
      blt_op = ($urandom_range(0, 3) == 0); bex_op = ($urandom_range(0, 4) == 0);
      ne = 1'($urandom); lt = 1'($urandom); rstatus_nz = 1'($urandom);
      target = 27'($urandom); imm = 17'($urandom); rd_val = $urandom;
      stall = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 0; stall = 0; clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
